// File: rtl/pri_rv32_pkg.sv
// Shared decode definitions for the priRV32 decode stage: opcodes, ALU codes, control-flag indices, bundle struct.
// No logic of its own; imported by pri_rv32_dec and pri_rv32_idu.
// No handshake of its own.
package pri_rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_MUL    = 4'd10;
    localparam logic [3:0] ALU_DIV    = 4'd14;

    localparam int CTRL_REG_WE  = 0;
    localparam int CTRL_MEM_RD  = 1;
    localparam int CTRL_MEM_WR  = 2;
    localparam int CTRL_BRANCH  = 3;
    localparam int CTRL_JAL     = 4;
    localparam int CTRL_JALR    = 5;
    localparam int CTRL_LUI     = 6;
    localparam int CTRL_AUIPC   = 7;
    localparam int CTRL_ILLEGAL = 8;
    localparam int CTRL_W       = 9;

    typedef struct packed {
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [31:0]       imm;
        logic [3:0]        alu_op;
        logic [CTRL_W-1:0] ctrl;
        logic              use_imm;
        logic [2:0]        funct3;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc;
        dec_t        dec;
    } entry_t;

    // funct3 -> ALU op for the funct7=0 register/immediate arithmetic group
    function automatic logic [3:0] alu_base(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pri_rv32_dec.sv
// Combinational RV32I instruction -> decoded bundle; M encodings decode only with PRIRV32_RV32M_EN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module pri_rv32_dec
    import pri_rv32_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        illegal;
    logic        reg_we;

    assign opcode = inst[6:0];
    assign funct7 = inst[31:25];
    assign funct3 = inst[14:12];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.rd     = inst[11:7];
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.funct3 = funct3;
        illegal    = 1'b0;
        reg_we     = 1'b0;
        case (opcode)
            OPC_LUI:    begin reg_we = 1'b1; dec.use_imm = 1'b1; dec.imm = imm_u; dec.ctrl[CTRL_LUI]   = 1'b1; end
            OPC_AUIPC:  begin reg_we = 1'b1; dec.use_imm = 1'b1; dec.imm = imm_u; dec.ctrl[CTRL_AUIPC] = 1'b1; end
            OPC_JAL:    begin reg_we = 1'b1; dec.use_imm = 1'b1; dec.imm = imm_j; dec.ctrl[CTRL_JAL]   = 1'b1; end
            OPC_JALR:   begin reg_we = 1'b1; dec.use_imm = 1'b1; dec.imm = imm_i; dec.ctrl[CTRL_JALR]  = 1'b1; end
            OPC_LOAD:   begin reg_we = 1'b1; dec.use_imm = 1'b1; dec.imm = imm_i; dec.ctrl[CTRL_MEM_RD] = 1'b1; end
            OPC_STORE:  begin dec.use_imm = 1'b1; dec.imm = imm_s; dec.ctrl[CTRL_MEM_WR] = 1'b1; end
            OPC_BRANCH: begin dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.ctrl[CTRL_BRANCH] = 1'b1; end
            OPC_OP_IMM: begin
                reg_we      = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                case (funct3)
                    3'b001: if (funct7 == F7_BASE) dec.alu_op = ALU_SLL; else illegal = 1'b1;
                    3'b101: begin
                        if (funct7 == F7_BASE)     dec.alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) dec.alu_op = ALU_SRA;
                        else                       illegal    = 1'b1;
                    end
                    default: dec.alu_op = alu_base(funct3);
                endcase
            end
            OPC_OP: begin
                reg_we = 1'b1;
                if (funct7 == F7_BASE)                         dec.alu_op = alu_base(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000) dec.alu_op = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_op = ALU_SRA;
`ifdef PRIRV32_RV32M_EN
                // REM/REMU share the DIV/DIVU codes; funct3 tells them apart downstream
                else if (funct7 == F7_MULDIV)
                    dec.alu_op = (funct3[2:1] == 2'b11) ? (ALU_DIV | {3'b000, funct3[0]})
                                                        : (ALU_MUL + {1'b0, funct3});
`endif
                else                                           illegal    = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec.alu_op              = ALU_ADD;
            dec.ctrl[CTRL_MEM_RD]   = 1'b0;
            dec.ctrl[CTRL_MEM_WR]   = 1'b0;
        end
        dec.ctrl[CTRL_ILLEGAL] = illegal;
        dec.ctrl[CTRL_REG_WE]  = reg_we & ~illegal & (dec.rd != 5'd0);
    end

endmodule

// File: rtl/pri_rv32_idu.sv
// Decode stage: registered decoded bundle behind an output+skid buffer; M decode via PRIRV32_RV32M_EN.
// Latency: 1 cycle from input transfer to id_valid_o when the output register is free.
// Backpressure: if_ready_o is the registered skid-empty flag; fetch never sees a path from id_ready_i.
module pri_rv32_idu
    import pri_rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_i,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_inst_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [4:0]  id_rd_o,
    output logic [31:0] id_imm_o,
    output logic [3:0]  id_alu_op_o,
    output logic [8:0]  id_ctrl_o,
    output logic        id_use_imm_o,
    output logic [2:0]  id_funct3_o,
    output logic [4:0]  reg_raddr1_o,
    output logic [4:0]  reg_raddr2_o
);

    dec_t   in_dec;
    entry_t in_entry;
    entry_t out_q;
    entry_t skid_q;
    logic   out_vld;
    logic   skid_vld;
    logic   in_xfer;
    logic   out_load;

    pri_rv32_dec u_dec (
        .inst (if_inst_i),
        .dec  (in_dec)
    );

    assign in_entry   = '{pc: if_pc_i, dec: in_dec};
    assign if_ready_o = ~skid_vld;
    assign in_xfer    = if_valid_i & if_ready_o;
    assign out_load   = ~out_vld | id_ready_i;

    // skid only fills while the output register is stalled, so skid_vld implies out_vld
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '{pc: RESET_PC, dec: '0};
            skid_q   <= '0;
        end else if (flush_i) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_load) begin
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (in_xfer) begin
                out_q    <= in_entry;
                out_vld  <= 1'b1;
            end else begin
                out_vld  <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_q   <= in_entry;
            skid_vld <= 1'b1;
        end
    end

    assign id_valid_o   = out_vld;
    assign id_pc_o      = out_q.pc;
    assign id_rd_o      = out_q.dec.rd;
    assign id_imm_o     = out_q.dec.imm;
    assign id_alu_op_o  = out_q.dec.alu_op;
    assign id_ctrl_o    = out_q.dec.ctrl;
    assign id_use_imm_o = out_q.dec.use_imm;
    assign id_funct3_o  = out_q.dec.funct3;
    assign reg_raddr1_o = out_q.dec.rs1;
    assign reg_raddr2_o = out_q.dec.rs2;

endmodule

// File: tb/tb_pri_rv32_idu.sv
// Bench for pri_rv32_idu: directed decode/handshake/flush/reset steps plus random traffic against a queue model.
module tb_pri_rv32_idu;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PRIRV32_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [4:0]  id_rd_o;
    logic [31:0] id_imm_o;
    logic [3:0]  id_alu_op_o;
    logic [8:0]  id_ctrl_o;
    logic        id_use_imm_o;
    logic [2:0]  id_funct3_o;
    logic [4:0]  reg_raddr1_o;
    logic [4:0]  reg_raddr2_o;

    int errors = 0;
    int checks = 0;
    logic [95:0] q[$];

    always #5 clk_in = ~clk_in;

    pri_rv32_idu #(.RESET_PC(RESET_PC)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .flush_i      (flush_i),
        .if_valid_i   (if_valid_i),
        .if_ready_o   (if_ready_o),
        .if_pc_i      (if_pc_i),
        .if_inst_i    (if_inst_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_pc_o      (id_pc_o),
        .id_rd_o      (id_rd_o),
        .id_imm_o     (id_imm_o),
        .id_alu_op_o  (id_alu_op_o),
        .id_ctrl_o    (id_ctrl_o),
        .id_use_imm_o (id_use_imm_o),
        .id_funct3_o  (id_funct3_o),
        .reg_raddr1_o (reg_raddr1_o),
        .reg_raddr2_o (reg_raddr2_o)
    );

    // Expected bundle {pc, rd, rs1, rs2, imm, alu, ctrl, use_imm, funct3} from the ISA rules
    function automatic logic [95:0] model(input logic [31:0] pc, input logic [31:0] inst);
        int base_tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int f3, f7, alu;
        logic [31:0] imm, i_imm, s_imm, b_imm, j_imm, u_imm;
        logic ill, we, mr, mw, br, jl, jr, lu, au, ui;
        f3 = int'(inst[14:12]);
        f7 = int'(inst[31:25]);
        i_imm = 32'($signed(inst[31:20]));
        s_imm = 32'($signed({inst[31:25], inst[11:7]}));
        b_imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8]})) << 1;
        j_imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21]})) << 1;
        u_imm = inst & 32'hFFFF_F000;
        {ill, we, mr, mw, br, jl, jr, lu, au, ui} = '0;
        imm = '0;
        alu = 0;
        case (inst[6:0])
            7'h37: begin lu = 1; we = 1; ui = 1; imm = u_imm; end
            7'h17: begin au = 1; we = 1; ui = 1; imm = u_imm; end
            7'h6F: begin jl = 1; we = 1; ui = 1; imm = j_imm; end
            7'h67: begin jr = 1; we = 1; ui = 1; imm = i_imm; end
            7'h03: begin mr = 1; we = 1; ui = 1; imm = i_imm; end
            7'h23: begin mw = 1; ui = 1; imm = s_imm; end
            7'h63: begin br = 1; alu = 1; imm = b_imm; end
            7'h13: begin
                we = 1; ui = 1; imm = i_imm; alu = base_tbl[f3];
                if (f3 == 1 && f7 != 0) ill = 1;
                if (f3 == 5 && f7 == 32) alu = 7;
                else if (f3 == 5 && f7 != 0) ill = 1;
            end
            7'h33: begin
                we = 1;
                if (f7 == 0)                alu = base_tbl[f3];
                else if (f7 == 32 && f3 == 0) alu = 1;
                else if (f7 == 32 && f3 == 5) alu = 7;
                else if (f7 == 1 && M_EN)   alu = (f3 < 6) ? 10 + f3 : 8 + f3;
                else                        ill = 1;
            end
            default: ill = 1;
        endcase
        if (ill) begin we = 0; mr = 0; mw = 0; alu = 0; end
        if (inst[11:7] == 5'd0) we = 0;
        return {pc, inst[11:7], inst[19:15], inst[24:20], imm, 4'(alu),
                {ill, au, lu, jr, jl, br, mw, mr, we}, ui, inst[14:12]};
    endfunction

    function automatic logic [95:0] observed();
        return {id_pc_o, id_rd_o, reg_raddr1_o, reg_raddr2_o, id_imm_o, id_alu_op_o,
                id_ctrl_o, id_use_imm_o, id_funct3_o};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at the falling edge, then advance the model at the rising edge
    task automatic tick();
        logic in_x, out_x, fl;
        logic [95:0] exp_in;
        @(negedge clk_in);
        chk("valid_vs_model", 128'(id_valid_o), 128'(q.size() != 0));
        chk("ready_vs_model", 128'(if_ready_o), 128'(q.size() < 2));
        if (id_valid_o && q.size() != 0) chk("bundle", 128'(observed()), 128'(q[0]));
        in_x   = if_valid_i & if_ready_o;
        out_x  = id_valid_o & id_ready_i;
        fl     = flush_i;
        exp_in = model(if_pc_i, if_inst_i);
        @(posedge clk_in);
        if (fl) q.delete();
        else begin
            if (out_x && q.size() != 0) void'(q.pop_front());
            if (in_x) q.push_back(exp_in);
        end
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] inst);
        if_valid_i = vld;
        if_pc_i    = pc;
        if_inst_i  = inst;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        logic [31:0] w;
        int sel, r;
        w   = $urandom;
        sel = $urandom_range(0, 11);
        if (sel < 9) begin
            w[6:0] = opcs[sel];
            r = $urandom_range(0, 3);
            if (sel >= 7) begin
                if (r == 0)      w[31:25] = 7'h00;
                else if (r == 1) w[31:25] = 7'h20;
                else if (r == 2) w[31:25] = 7'h01;
            end
        end
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        rst_in = 1'b1; flush_i = 1'b0; id_ready_i = 1'b0;
        drive(1'b0, '0, '0);
        #2;
        chk("reset_valid", 128'(id_valid_o), 128'(0));
        chk("reset_ready", 128'(if_ready_o), 128'(1));
        chk("reset_bundle", 128'(observed()), 128'({RESET_PC, 64'd0}));
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // basic decode: addi x1,x0,5
        id_ready_i = 1'b1;
        drive(1'b1, 32'h100, 32'h0050_0093);
        tick();
        chk("addi_valid", 128'(id_valid_o), 128'(1));
        chk("addi_rd", 128'(id_rd_o), 128'(5'd1));
        chk("addi_raddr1", 128'(reg_raddr1_o), 128'(5'd0));
        chk("addi_imm", 128'(id_imm_o), 128'(32'd5));
        chk("addi_alu", 128'(id_alu_op_o), 128'(4'd0));
        chk("addi_we", 128'(id_ctrl_o[0]), 128'(1));
        chk("addi_use_imm", 128'(id_use_imm_o), 128'(1));

        // branch immediate: beq x0,x0,-4
        drive(1'b1, 32'h104, 32'hFE00_0EE3);
        tick();
        chk("beq_branch", 128'(id_ctrl_o[3]), 128'(1));
        chk("beq_imm", 128'(id_imm_o), 128'(32'hFFFF_FFFC));
        chk("beq_alu", 128'(id_alu_op_o), 128'(4'd1));
        chk("beq_we", 128'(id_ctrl_o[0]), 128'(0));

        // M-extension gating: mul x3,x1,x2
        drive(1'b1, 32'h108, 32'h0220_81B3);
        tick();
        chk("mul_rd", 128'(id_rd_o), 128'(5'd3));
`ifdef PRIRV32_RV32M_EN
        chk("mul_alu", 128'(id_alu_op_o), 128'(4'd10));
        chk("mul_illegal", 128'(id_ctrl_o[8]), 128'(0));
`else
        chk("mul_illegal", 128'(id_ctrl_o[8]), 128'(1));
        chk("mul_we", 128'(id_ctrl_o[0]), 128'(0));
`endif

        // all-zero word is illegal but still delivered
        drive(1'b1, 32'h10C, 32'h0000_0000);
        tick();
        chk("zero_illegal", 128'(id_ctrl_o[8]), 128'(1));
        chk("zero_valid", 128'(id_valid_o), 128'(1));
        drive(1'b0, '0, '0);
        tick();

        // back-pressure: three instructions with the consumer stalled
        id_ready_i = 1'b0;
        drive(1'b1, 32'h200, 32'h0010_0113);
        tick();
        drive(1'b1, 32'h204, 32'h0020_0193);
        tick();
        drive(1'b1, 32'h208, 32'h0030_0213);
        tick();
        chk("bp_ready_low", 128'(if_ready_o), 128'(0));
        chk("bp_head_pc", 128'(id_pc_o), 128'(32'h200));
        id_ready_i = 1'b1;
        tick();
        chk("bp_second_valid", 128'(id_valid_o), 128'(1));
        chk("bp_second_pc", 128'(id_pc_o), 128'(32'h204));
        tick();
        drive(1'b0, '0, '0);
        chk("bp_third_valid", 128'(id_valid_o), 128'(1));
        chk("bp_third_pc", 128'(id_pc_o), 128'(32'h208));
        tick();
        chk("bp_drained", 128'(id_valid_o), 128'(0));

        // flush with both entries full and a pending input
        id_ready_i = 1'b0;
        drive(1'b1, 32'h300, 32'h0010_0093);
        tick();
        drive(1'b1, 32'h304, 32'h0010_0093);
        tick();
        drive(1'b1, 32'h308, 32'h0010_0093);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, '0, '0);
        chk("flush_valid", 128'(id_valid_o), 128'(0));
        chk("flush_ready", 128'(if_ready_o), 128'(1));
        chk("flush_data_kept", 128'(id_pc_o), 128'(32'h300));

        // flush drops an input that handshakes in the same cycle
        drive(1'b1, 32'h400, 32'h0010_0093);
        tick();
        drive(1'b1, 32'h404, 32'h0020_0093);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, '0, '0);
        id_ready_i = 1'b1;
        repeat (3) tick();
        chk("flush_dropped", 128'(id_valid_o), 128'(0));

        // random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            id_ready_i = ($urandom_range(0, 2) != 0);
            flush_i    = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, rand_inst());
            tick();
        end
        flush_i = 1'b0;

        // asynchronous reset mid-stream with both entries full
        id_ready_i = 1'b0;
        drive(1'b1, 32'h500, 32'h0010_0093);
        tick();
        drive(1'b1, 32'h504, 32'h0010_0093);
        tick();
        drive(1'b0, '0, '0);
        tick();
        chk("prerst_full", 128'(if_ready_o), 128'(0));
        #3;
        rst_in = 1'b1;
        #1;
        q.delete();
        chk("arst_valid", 128'(id_valid_o), 128'(0));
        chk("arst_ready", 128'(if_ready_o), 128'(1));
        chk("arst_bundle", 128'(observed()), 128'({RESET_PC, 64'd0}));
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        id_ready_i = 1'b1;
        repeat (2) tick();
        chk("post_rst_empty", 128'(id_valid_o), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
